multi_mode_game_counter: RTL and testbench

- Parametrised multi-mode up/down game counter with sticky win/loss tallies and a game-over state machine.
- Next generation of the team's count-up/down game block: configurable width, limit, large step, win target and wrap/saturate mode.
- All state is synchronous to one clock; game state is held until an explicit clear or init.
- Sits as a leaf under the counter test harness and is driven by the stimulus interface.

---
 rtl/counter_pkg.sv | 24 ++
 rtl/step_alu.sv | 57 +++++
 rtl/multi_mode_game_counter.sv | 144 ++++++++++++++
 tb/tb_multi_mode_game_counter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types for the multi-mode game counter.
//   count_mode_e : 2-bit control codes selecting the step direction/size
//   game_state_e : game FSM states
//   WHO_*        : encodings driven on the 'who' output
package counter_pkg;

   typedef enum logic [1:0] {
      UP1 = 2'b00,   // +1
      UPN = 2'b01,   // +STEP_LARGE
      DN1 = 2'b10,   // -1
      DNN = 2'b11    // -STEP_LARGE
   } count_mode_e;

   typedef enum logic [1:0] {
      PLAY   = 2'd0,
      OVER_W = 2'd1,
      OVER_L = 2'd2
   } game_state_e;

   localparam logic [1:0] WHO_NONE   = 2'b00;
   localparam logic [1:0] WHO_LOSER  = 2'b01;
   localparam logic [1:0] WHO_WINNER = 2'b10;

endpackage

// File: rtl/step_alu.sv
// Combinational next-count for the game counter.
//   count_in  : current count, always within [0, MAX_VALUE]
//   control   : count_mode_e code selecting +1, +STEP_LARGE, -1, -STEP_LARGE
//   count_out : stepped count, wrapped modulo MAX_VALUE+1 or clamped to
//               [0, MAX_VALUE] depending on SATURATE
module step_alu
   import counter_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int MAX_VALUE  = 15,
   parameter int STEP_LARGE = 2,
   parameter int SATURATE   = 0
) (
   input  logic [WIDTH-1:0] count_in,
   input  logic [1:0]       control,
   output logic [WIDTH-1:0] count_out
);

   // Two guard bits: the sum spans [-MAX_VALUE, 2*MAX_VALUE], and 2*MAX_VALUE
   // does not fit a WIDTH+1 bit signed value when MAX_VALUE = 2**WIDTH-1.
   localparam int SW = WIDTH + 2;
   localparam logic signed [SW-1:0] ONE_S  = SW'(1);
   localparam logic signed [SW-1:0] STEP_S = SW'(STEP_LARGE);
   localparam logic signed [SW-1:0] MAX_S  = SW'(MAX_VALUE);
   localparam logic signed [SW-1:0] MOD_S  = SW'(MAX_VALUE + 1);

   logic signed [SW-1:0] delta;
   logic signed [SW-1:0] sum;
   logic signed [SW-1:0] res;

   always_comb begin
      delta = '0;
      case (count_mode_e'(control))
         UP1:     delta = ONE_S;
         UPN:     delta = STEP_S;
         DN1:     delta = -ONE_S;
         DNN:     delta = -STEP_S;
         default: delta = '0;
      endcase

      sum = signed'({2'b00, count_in}) + delta;
      res = sum;

      // One correction is enough: |delta| <= MAX_VALUE keeps the sum within
      // one modulus of the legal range.
      if (SATURATE != 0) begin
         if (sum < 0)          res = '0;
         else if (sum > MAX_S) res = MAX_S;
      end else begin
         if (sum < 0)          res = sum + MOD_S;
         else if (sum > MAX_S) res = sum - MOD_S;
      end
   end

   assign count_out = WIDTH'(res);

endmodule

// File: rtl/multi_mode_game_counter.sv
// Multi-mode up/down game counter with sticky win/loss tallies.
//   clk, rst              : rising-edge clock, synchronous active-high reset
//   clear                 : zero count and tallies, back to PLAY
//   init, initial_value   : load min(initial_value, MAX_VALUE), zero tallies
//   control, enable       : step selection and count enable (PLAY only)
//   count                 : registered count
//   winner / loser        : count at MAX_VALUE / at 0
//   cnt_winner/cnt_loser  : number of arrivals at each limit
//   gameover, who         : game result once a tally reaches WIN_TARGET
//   state_dbg             : current game FSM state
module multi_mode_game_counter
   import counter_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int MAX_VALUE  = 15,
   parameter int STEP_LARGE = 2,
   parameter int WIN_TARGET = 15,
   parameter int TALLY_W    = $clog2(WIN_TARGET + 1),
   parameter int SATURATE   = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               init,
   input  logic [WIDTH-1:0]   initial_value,
   input  logic [1:0]         control,
   input  logic               enable,
   output logic [WIDTH-1:0]   count,
   output logic               winner,
   output logic               loser,
   output logic [TALLY_W-1:0] cnt_winner,
   output logic [TALLY_W-1:0] cnt_loser,
   output logic               gameover,
   output logic [1:0]         who,
   output game_state_e        state_dbg
);

   localparam logic [WIDTH-1:0]   MAX_W   = WIDTH'(MAX_VALUE);
   localparam logic [TALLY_W-1:0] TARGET_T = TALLY_W'(WIN_TARGET);

   logic [WIDTH-1:0]   count_q, count_d;
   logic [TALLY_W-1:0] cnt_w_q, cnt_w_d;
   logic [TALLY_W-1:0] cnt_l_q, cnt_l_d;
   logic               win_q, win_d;
   logic               lose_q, lose_d;
   game_state_e        state_q, state_d;

   logic [WIDTH-1:0]   alu_count;
   logic [WIDTH-1:0]   init_val;
   logic [TALLY_W-1:0] cnt_w_inc;
   logic [TALLY_W-1:0] cnt_l_inc;
   logic               win_arrival;
   logic               lose_arrival;

   step_alu #(
      .WIDTH      (WIDTH),
      .MAX_VALUE  (MAX_VALUE),
      .STEP_LARGE (STEP_LARGE),
      .SATURATE   (SATURATE)
   ) u_step_alu (
      .count_in  (count_q),
      .control   (control),
      .count_out (alu_count)
   );

   assign winner       = (count_q == MAX_W);
   assign loser        = (count_q == '0);
   assign init_val     = (initial_value > MAX_W) ? MAX_W : initial_value;
   assign cnt_w_inc    = cnt_w_q + TALLY_W'(1);
   assign cnt_l_inc    = cnt_l_q + TALLY_W'(1);
   // An arrival is the first cycle spent at a limit; dwelling scores once.
   assign win_arrival  = winner && !win_q;
   assign lose_arrival = loser && !lose_q;

   always_comb begin
      count_d = count_q;
      cnt_w_d = cnt_w_q;
      cnt_l_d = cnt_l_q;
      state_d = state_q;
      win_d   = winner;
      lose_d  = loser;

      if (clear) begin
         count_d = '0;
         cnt_w_d = '0;
         cnt_l_d = '0;
         state_d = PLAY;
         win_d   = 1'b0;
         lose_d  = 1'b1;
      end else if (init) begin
         count_d = init_val;
         cnt_w_d = '0;
         cnt_l_d = '0;
         state_d = PLAY;
         // Edge detectors see the loaded value as already present.
         win_d   = (init_val == MAX_W);
         lose_d  = (init_val == '0);
      end else if (state_q == PLAY) begin
         if (enable) count_d = alu_count;
         // winner and loser are exclusive since MAX_VALUE >= 1.
         if (win_arrival) begin
            cnt_w_d = cnt_w_inc;
            if (cnt_w_inc == TARGET_T) state_d = OVER_W;
         end else if (lose_arrival) begin
            cnt_l_d = cnt_l_inc;
            if (cnt_l_inc == TARGET_T) state_d = OVER_L;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         cnt_w_q <= '0;
         cnt_l_q <= '0;
         state_q <= PLAY;
         win_q   <= 1'b0;
         lose_q  <= 1'b1;
      end else begin
         count_q <= count_d;
         cnt_w_q <= cnt_w_d;
         cnt_l_q <= cnt_l_d;
         state_q <= state_d;
         win_q   <= win_d;
         lose_q  <= lose_d;
      end
   end

   always_comb begin
      who = WHO_NONE;
      case (state_q)
         OVER_W:  who = WHO_WINNER;
         OVER_L:  who = WHO_LOSER;
         default: who = WHO_NONE;
      endcase
   end

   assign gameover   = (state_q != PLAY);
   assign count      = count_q;
   assign cnt_winner = cnt_w_q;
   assign cnt_loser  = cnt_l_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_multi_mode_game_counter.sv
// Four counters with different parameters share one directed stimulus
// stream; each has its own behavioural model, checked every cycle.
//   u0: defaults (wrap)          u1: SATURATE = 1
//   u2: WIN_TARGET = 2           u3: WIDTH = 5, MAX_VALUE = 15
module tb_multi_mode_game_counter;
   import counter_pkg::*;

   logic       clk = 1'b0;
   logic       rst, clear, init, enable;
   logic [4:0] iv;
   logic [1:0] control;

   logic [3:0] count0, count1, count2;
   logic [4:0] count3;
   logic       win0, win1, win2, win3, lose0, lose1, lose2, lose3;
   logic [3:0] cw0, cw1, cw3, cl0, cl1, cl3;
   logic [1:0] cw2, cl2;
   logic       go0, go1, go2, go3;
   logic [1:0] who0, who1, who2, who3;
   game_state_e st0, st1, st2, st3;

   int n_checks = 0;
   int n_errors = 0;
   bit started  = 1'b0;

   // model parameters per instance
   int p_w[4]    = '{4, 4, 4, 5};
   int p_max[4]  = '{15, 15, 15, 15};
   int p_step[4] = '{2, 2, 2, 2};
   int p_wt[4]   = '{15, 15, 2, 15};
   int p_sat[4]  = '{0, 1, 0, 0};

   // model state: count, "was at max/zero last cycle", tallies, result
   int m_cnt[4], m_tw[4], m_tl[4], m_res[4]; // m_res: 0 play, 1 won, 2 lost
   bit m_wp[4], m_lp[4];

   always #5 clk = ~clk;

   multi_mode_game_counter u0 (
      .clk(clk), .rst(rst), .clear(clear), .init(init), .initial_value(iv[3:0]),
      .control(control), .enable(enable), .count(count0), .winner(win0), .loser(lose0),
      .cnt_winner(cw0), .cnt_loser(cl0), .gameover(go0), .who(who0), .state_dbg(st0));

   multi_mode_game_counter #(.SATURATE(1)) u1 (
      .clk(clk), .rst(rst), .clear(clear), .init(init), .initial_value(iv[3:0]),
      .control(control), .enable(enable), .count(count1), .winner(win1), .loser(lose1),
      .cnt_winner(cw1), .cnt_loser(cl1), .gameover(go1), .who(who1), .state_dbg(st1));

   multi_mode_game_counter #(.WIN_TARGET(2)) u2 (
      .clk(clk), .rst(rst), .clear(clear), .init(init), .initial_value(iv[3:0]),
      .control(control), .enable(enable), .count(count2), .winner(win2), .loser(lose2),
      .cnt_winner(cw2), .cnt_loser(cl2), .gameover(go2), .who(who2), .state_dbg(st2));

   multi_mode_game_counter #(.WIDTH(5), .MAX_VALUE(15)) u3 (
      .clk(clk), .rst(rst), .clear(clear), .init(init), .initial_value(iv),
      .control(control), .enable(enable), .count(count3), .winner(win3), .loser(lose3),
      .cnt_winner(cw3), .cnt_loser(cl3), .gameover(go3), .who(who3), .state_dbg(st3));

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   task automatic model_edge(input int i);
      int m, v, nxt, delta;
      bit at_max, at_zero;
      m = p_max[i];
      if (rst || clear) begin
         m_cnt[i] = 0; m_tw[i] = 0; m_tl[i] = 0; m_res[i] = 0;
         m_wp[i] = 1'b0; m_lp[i] = 1'b1;
      end else if (init) begin
         v = int'(iv) % (1 << p_w[i]);
         m_cnt[i] = (v > m) ? m : v;
         m_tw[i] = 0; m_tl[i] = 0; m_res[i] = 0;
         m_wp[i] = (m_cnt[i] == m); m_lp[i] = (m_cnt[i] == 0);
      end else begin
         at_max  = (m_cnt[i] == m);
         at_zero = (m_cnt[i] == 0);
         if (m_res[i] == 0) begin
            if (at_max && !m_wp[i]) begin
               m_tw[i]++;
               if (m_tw[i] == p_wt[i]) m_res[i] = 1;
            end
            if (at_zero && !m_lp[i]) begin
               m_tl[i]++;
               if (m_tl[i] == p_wt[i]) m_res[i] = 2;
            end
            if (enable) begin
               case (control)
                  2'b00:   delta = 1;
                  2'b01:   delta = p_step[i];
                  2'b10:   delta = -1;
                  default: delta = -p_step[i];
               endcase
               nxt = m_cnt[i] + delta;
               if (p_sat[i] != 0) nxt = (nxt < 0) ? 0 : (nxt > m) ? m : nxt;
               else               nxt = ((nxt % (m + 1)) + m + 1) % (m + 1);
               m_cnt[i] = nxt;
            end
         end
         m_wp[i] = at_max;
         m_lp[i] = at_zero;
      end
   endtask

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) model_edge(i);
      started <= 1'b1;
   end

   task automatic cmp_inst(input int i, input int c, input int w, input int l,
                           input int tw, input int tl, input int go, input int wh,
                           input int st);
      game_state_e exp_st;
      exp_st = (m_res[i] == 1) ? OVER_W : (m_res[i] == 2) ? OVER_L : PLAY;
      chk($sformatf("u%0d.count", i), c, m_cnt[i]);
      chk($sformatf("u%0d.winner", i), w, int'(m_cnt[i] == p_max[i]));
      chk($sformatf("u%0d.loser", i), l, int'(m_cnt[i] == 0));
      chk($sformatf("u%0d.cnt_winner", i), tw, m_tw[i]);
      chk($sformatf("u%0d.cnt_loser", i), tl, m_tl[i]);
      chk($sformatf("u%0d.gameover", i), go, int'(m_res[i] != 0));
      chk($sformatf("u%0d.who", i), wh, (m_res[i] == 1) ? 2 : (m_res[i] == 2) ? 1 : 0);
      chk($sformatf("u%0d.state", i), st, int'(exp_st));
   endtask

   always @(negedge clk) begin
      if (started) begin
         cmp_inst(0, count0, win0, lose0, cw0, cl0, go0, who0, st0);
         cmp_inst(1, count1, win1, lose1, cw1, cl1, go1, who1, st1);
         cmp_inst(2, count2, win2, lose2, cw2, cl2, go2, who2, st2);
         cmp_inst(3, count3, win3, lose3, cw3, cl3, go3, who3, st3);
      end
   end

   // ---------------- driver ----------------
   task automatic drive(input bit r, input bit c, input bit in, input logic [4:0] v,
                        input logic [1:0] ctl, input bit en);
      rst = r; clear = c; init = in; iv = v; control = ctl; enable = en;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; init = 1'b0; iv = '0; control = 2'b00; enable = 1'b0;

      // reset state
      drive(1, 0, 0, 0, 2'b00, 0);
      chk("lit_reset_count", count0, 0);
      chk("lit_reset_loser", lose0, 1);
      chk("lit_reset_winner", win0, 0);
      chk("lit_reset_who", who0, 0);

      // count up 0..15, then the winner arrival scores one edge later
      for (int k = 1; k <= 15; k++) begin
         drive(0, 0, 0, 0, 2'b00, 1);
         if (k == 1) chk("lit_reset_no_loser", cl0, 0);
      end
      chk("lit_up_count15", count0, 15);
      chk("lit_up_cw_before", cw0, 0);
      drive(0, 0, 0, 0, 2'b00, 1);
      chk("lit_up_wrap0", count0, 0);
      chk("lit_up_cw1", cw0, 1);
      chk("lit_sat_hold15", count1, 15);

      // init 1 then -STEP_LARGE: wrap 1,15,13,11; saturate 1,0,0,0
      drive(0, 0, 1, 5'd1, 2'b00, 0);
      chk("lit_init1", count0, 1);
      chk("lit_init_cw0", cw0, 0);
      drive(0, 0, 0, 0, 2'b11, 1);
      chk("lit_wrap_15", count0, 15);
      chk("lit_sat_0", count1, 0);
      drive(0, 0, 0, 0, 2'b11, 1);
      chk("lit_wrap_13", count0, 13);
      chk("lit_wrap_cw", cw0, 1);
      chk("lit_sat_cl", cl1, 1);
      drive(0, 0, 0, 0, 2'b11, 1);
      chk("lit_wrap_11", count0, 11);
      chk("lit_sat_dwell", cl1, 1);

      // WIN_TARGET = 2: reach 15 twice, ending in OVER_W while holding
      drive(0, 0, 1, 5'd14, 2'b00, 0);
      drive(0, 0, 0, 0, 2'b00, 1);   // 15
      drive(0, 0, 0, 0, 2'b11, 1);   // 13, first arrival
      drive(0, 0, 0, 0, 2'b00, 1);   // 14
      drive(0, 0, 0, 0, 2'b00, 1);   // 15
      drive(0, 0, 0, 0, 2'b00, 0);   // second arrival
      chk("lit_over_w_cw", cw2, 2);
      chk("lit_over_w_go", go2, 1);
      chk("lit_over_w_who", who2, 2);
      for (int k = 0; k < 10; k++) drive(0, 0, 0, 0, 2'b00, 1);
      chk("lit_over_w_frozen", count2, 15);

      // leave OVER_W with clear, then drive into OVER_L
      drive(0, 1, 0, 0, 2'b00, 1);
      chk("lit_clear_count", count2, 0);
      chk("lit_clear_go", go2, 0);
      drive(0, 0, 0, 0, 2'b00, 1);
      drive(0, 0, 0, 0, 2'b10, 1);
      drive(0, 0, 0, 0, 2'b00, 1);
      drive(0, 0, 0, 0, 2'b10, 1);
      drive(0, 0, 0, 0, 2'b00, 0);
      chk("lit_over_l_cl", cl2, 2);
      chk("lit_over_l_who", who2, 1);
      drive(0, 1, 0, 0, 2'b00, 0);
      chk("lit_clear_l_cl", cl2, 0);
      chk("lit_clear_l_who", who2, 0);
      drive(0, 0, 0, 0, 2'b00, 0);
      chk("lit_clear_no_score", cl2, 0);

      // rst beats clear and init; init above MAX_VALUE clamps
      drive(1, 1, 1, 5'd9, 2'b00, 1);
      chk("lit_rst_wins", count0, 0);
      drive(0, 0, 1, 5'd20, 2'b00, 0);
      chk("lit_init_clamp", count3, 15);
      chk("lit_init_trunc", count0, 4);
      drive(0, 0, 0, 0, 2'b00, 0);
      chk("lit_init_no_score", cw3, 0);

      // enable low: everything holds across all control codes
      drive(0, 0, 1, 5'd7, 2'b00, 0);
      for (int k = 0; k < 8; k++) drive(0, 0, 0, 0, 2'(k % 4), 0);
      chk("lit_hold_count", count0, 7);
      chk("lit_hold_cw", cw0, 0);
      chk("lit_hold_sat", count1, 7);

      // mixed directed walk across both limits with large steps
      for (int k = 0; k < 12; k++) drive(0, 0, 0, 0, 2'b01, 1);
      for (int k = 0; k < 12; k++) drive(0, 0, 0, 0, 2'b11, (k % 3) != 2);
      for (int k = 0; k < 8; k++) drive(0, 0, 0, 0, 2'(k % 4), 1);

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
